// File: rtl/inst_fetch_axi_pkg.sv
// Shared types and constants for the AXI instruction-fetch stage.
// The IF state encoding, the fixed single-beat AXI AR attributes and the
// sequential-PC helper live here so the top stays focused on control flow.
package inst_fetch_axi_pkg;

    // Fetch FSM states: waiting, address phase, data phase, and draining a
    // response that a flush made stale.
    typedef enum logic [1:0] {
        IF_IDLE    = 2'd0,
        IF_ADDR    = 2'd1,
        IF_DATA    = 2'd2,
        IF_DISCARD = 2'd3
    } if_state_e;

    localparam logic [31:0] ZERO_WORD      = 32'h0000_0000;
    localparam logic [7:0]  AXI_LEN_SINGLE = 8'd0;
    localparam logic [2:0]  AXI_SIZE_WORD  = 3'd2;
    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;

    // Next sequential instruction address; wraps naturally at 2^32.
    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/inst_fetch_axi.sv
// Instruction-fetch stage with a single-outstanding AXI4 read master.
// Owns the PC, issues one-beat reads when IF/ID asks for the next word and
// presents each returned word as a one-cycle valid pulse. Branches take effect
// after the delay slot; flushes redirect at once and drop in-flight responses.
// Optional feature macro: INST_FETCH_ALIGN_CHECK_EN (misaligned-PC fetch
// raises if_excp_adel instead of issuing a read).
module inst_fetch_axi
    import inst_fetch_axi_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter logic [3:0]  AXI_ID   = 4'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    input  logic        next_pc_valid,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,
    output logic        valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_excp_adel
);

    if_state_e   state_reg;
    logic [31:0] pc_reg;
    logic [31:0] pending_target_reg;
    logic        branch_pending_reg;
    logic        flush_seen_reg;   // flush arrived while AR was still pending
    logic        start_fetch;
    logic        deliver;
    logic [31:0] redirect_pc;

    // Only stall[0] gates this stage; the rest of the vector belongs to later stages.
    logic unused_stall;
    assign unused_stall = ^stall[5:1];

    assign arid    = AXI_ID;
    assign arlen   = AXI_LEN_SINGLE;
    assign arsize  = AXI_SIZE_WORD;
    assign arburst = AXI_BURST_INCR;

    assign start_fetch = next_pc_valid && !stall[0] && !flush;
    assign deliver     = (state_reg == IF_DATA) && rvalid && !flush;
    // A branch latched earlier wins; otherwise a branch resolved in the
    // delivery cycle applies directly, else fall through sequentially.
    assign redirect_pc = branch_pending_reg ? pending_target_reg :
                         (branch_flag ? branch_target : seq_pc(pc_reg));

`ifdef INST_FETCH_ALIGN_CHECK_EN
    logic adel_reg;
    assign if_excp_adel = adel_reg;
`else
    assign if_excp_adel = 1'b0;
`endif

    // PC / branch bookkeeping and the fetch FSM with its registered AXI and IF/ID outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg          <= IF_IDLE;
            pc_reg             <= RESET_PC;
            pending_target_reg <= ZERO_WORD;
            branch_pending_reg <= 1'b0;
            flush_seen_reg     <= 1'b0;
            araddr             <= ZERO_WORD;
            arvalid            <= 1'b0;
            rready             <= 1'b0;
            valid              <= 1'b0;
            if_pc              <= ZERO_WORD;
            if_inst            <= ZERO_WORD;
`ifdef INST_FETCH_ALIGN_CHECK_EN
            adel_reg           <= 1'b0;
`endif
        end else begin
            valid <= 1'b0;
`ifdef INST_FETCH_ALIGN_CHECK_EN
            adel_reg <= 1'b0;
`endif
            if (flush) begin
                pc_reg             <= new_pc;
                branch_pending_reg <= 1'b0;
            end else if (deliver) begin
                pc_reg             <= redirect_pc;
                branch_pending_reg <= 1'b0;
            end else if (branch_flag) begin
                branch_pending_reg <= 1'b1;
                pending_target_reg <= branch_target;
            end

            case (state_reg)
                IF_IDLE: begin
                    if (start_fetch) begin
`ifdef INST_FETCH_ALIGN_CHECK_EN
                        if (pc_reg[1:0] != 2'b00) begin
                            valid    <= 1'b1;
                            if_pc    <= pc_reg;
                            if_inst  <= ZERO_WORD;
                            adel_reg <= 1'b1;
                        end else begin
                            araddr    <= pc_reg;
                            arvalid   <= 1'b1;
                            state_reg <= IF_ADDR;
                        end
`else
                        araddr    <= pc_reg;
                        arvalid   <= 1'b1;
                        state_reg <= IF_ADDR;
`endif
                    end
                end
                IF_ADDR: begin
                    // AR cannot be withdrawn once raised; remember the flush instead.
                    if (flush) begin
                        flush_seen_reg <= 1'b1;
                    end
                    if (arready) begin
                        arvalid        <= 1'b0;
                        rready         <= 1'b1;
                        flush_seen_reg <= 1'b0;
                        state_reg      <= (flush || flush_seen_reg) ? IF_DISCARD : IF_DATA;
                    end
                end
                IF_DATA: begin
                    if (rvalid) begin
                        rready    <= 1'b0;
                        state_reg <= IF_IDLE;
                        if (!flush) begin
                            valid   <= 1'b1;
                            if_pc   <= araddr;
                            if_inst <= rdata;
                        end
                    end else if (flush) begin
                        state_reg <= IF_DISCARD;
                    end
                end
                IF_DISCARD: begin
                    if (rvalid) begin
                        rready    <= 1'b0;
                        state_reg <= IF_IDLE;
                    end
                end
                default: state_reg <= IF_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_axi.sv
// Self-checking bench for inst_fetch_axi: directed scenarios plus a randomized
// run against a transaction-level reference model (architectural PC, pending
// branch, and whether the single in-flight read has been invalidated).
module tb_inst_fetch_axi;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        next_pc_valid;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;
    logic        valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_excp_adel;

    inst_fetch_axi #(.RESET_PC(RESET_PC), .AXI_ID(4'h0)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
        .branch_flag(branch_flag), .branch_target(branch_target),
        .next_pc_valid(next_pc_valid), .arid(arid), .araddr(araddr),
        .arlen(arlen), .arsize(arsize), .arburst(arburst), .arvalid(arvalid),
        .arready(arready), .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .valid(valid), .if_pc(if_pc), .if_inst(if_inst), .if_excp_adel(if_excp_adel)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Slave configuration and state
    int          ar_delay = 0;
    int          r_delay = 0;
    bit          rand_delays = 0;
    bit          const_data = 1;
    bit          mon_en = 1;
    int          s_ar_cnt = 0;
    int          s_r_cnt = 0;
    bit          s_busy = 0;
    logic [31:0] s_addr = '0;

    // Reference model: architectural fetch PC, pending redirect, in-flight read
    logic [31:0] pc_m = RESET_PC;
    logic [31:0] tgt_m = '0;
    logic [31:0] addr_m = '0;
    bit          pend_m = 0;
    bit          txn_m = 0;
    bit          doomed_m = 0;

    // Values that were in force during the cycle leading to the last edge
    logic        p_rst, p_flush, p_branch, p_arvalid, p_arready, p_rvalid, p_rready;
    logic [31:0] p_new_pc, p_bt, p_araddr;

    int          valid_cnt = 0;
    int          rise_cnt = 0;
    logic [31:0] last_rise_addr = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (const_data) return 32'h2408_0001;
        return {a[15:0] ^ 16'hA5C3, a[31:16] ^ 16'h1234};
    endfunction

    // Advance the reference model over the edge just taken and compare.
    task automatic model_step();
        bit          ar_hs;
        bit          r_hs;
        bit          exp_v;
        logic [31:0] exp_pc;
        ar_hs  = p_arvalid && p_arready;
        r_hs   = p_rvalid && p_rready;
        exp_v  = 0;
        exp_pc = '0;
        if (p_rst) begin
            pc_m = RESET_PC; pend_m = 0; txn_m = 0; doomed_m = 0;
            s_busy = 0; s_ar_cnt = 0; s_r_cnt = 0;
            if (mon_en) begin
                check("rst_valid", valid, 0);
                check("rst_arvalid", arvalid, 0);
                check("rst_rready", rready, 0);
                check("rst_if_pc", if_pc, 0);
                check("rst_if_inst", if_inst, 0);
                check("rst_adel", if_excp_adel, 0);
            end
        end else begin
            if (ar_hs) begin
                s_busy = 1; s_addr = p_araddr; s_ar_cnt = 0; s_r_cnt = 0;
                if (rand_delays) begin
                    ar_delay = $urandom_range(0, 3);
                    r_delay  = $urandom_range(0, 3);
                end
            end
            if (r_hs) s_busy = 0;
            if (p_flush) begin
                pc_m = p_new_pc; pend_m = 0;
                if (txn_m) doomed_m = 1;
            end else if (r_hs && txn_m && !doomed_m) begin
                exp_v  = 1;
                exp_pc = addr_m;
                pc_m   = pend_m ? tgt_m : (p_branch ? p_bt : pc_m + 32'd4);
                pend_m = 0;
            end else if (p_branch) begin
                pend_m = 1; tgt_m = p_bt;
            end
            if (r_hs) begin
                txn_m = 0; doomed_m = 0;
            end
            if (mon_en) begin
                check("valid", valid, exp_v);
                if (exp_v) begin
                    check("if_pc", if_pc, exp_pc);
                    check("if_inst", if_inst, mem_word(exp_pc));
                    check("if_adel", if_excp_adel, 0);
                end
                if (p_arvalid && !p_arready) begin
                    check("arvalid_hold", arvalid, 1);
                    check("araddr_hold", araddr, p_araddr);
                end
            end
            if (arvalid && !p_arvalid) begin
                rise_cnt++;
                last_rise_addr = araddr;
                if (mon_en) begin
                    check("ar_overlap", txn_m, 0);
                    check("araddr", araddr, pc_m);
                end
                txn_m = 1; addr_m = araddr; doomed_m = 0;
            end
        end
        if (valid) begin
            valid_cnt++;
            $display("fetch pc=%h inst=%h adel=%0d", if_pc, if_inst, if_excp_adel);
        end
    endtask

    // One clock: slave drives its side, snapshot, edge, then model/compare.
    task automatic tick();
        arready = 1'b0;
        if (!s_busy && arvalid) begin
            arready = (s_ar_cnt >= ar_delay);
            s_ar_cnt++;
        end
        rvalid = 1'b0;
        rdata  = $urandom;
        if (s_busy) begin
            if (s_r_cnt >= r_delay) begin
                rvalid = 1'b1;
                rdata  = mem_word(s_addr);
            end
            s_r_cnt++;
        end
        p_rst = rst; p_flush = flush; p_branch = branch_flag;
        p_new_pc = new_pc; p_bt = branch_target;
        p_arvalid = arvalid; p_arready = arready; p_araddr = araddr;
        p_rvalid = rvalid; p_rready = rready;
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic wait_rise(input string tag, output logic [31:0] addr);
        int start;
        int n;
        start = rise_cnt;
        n = 0;
        while (rise_cnt == start && n < 60) begin
            tick();
            n++;
        end
        check({tag, "_ar_timeout"}, (rise_cnt != start) ? 32'd1 : 32'd0, 32'd1);
        addr = last_rise_addr;
    endtask

    task automatic do_reset();
        rst = 1'b1; stall = '0; flush = 1'b0; new_pc = '0; branch_flag = 1'b0;
        branch_target = '0; next_pc_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] rnd;
        int          n;
        int          v0;
        int          r0;
        arready = 1'b0; rvalid = 1'b0; rdata = '0;

        // 1: zero-wait fetch after reset, latency and sequential follow-up
        do_reset();
        check("arid", arid, 32'd0);
        tick();
        next_pc_valid = 1'b1;
        v0 = valid_cnt;
        n = 0;
        while (valid_cnt == v0 && n < 20) begin
            tick();
            n++;
        end
        check("t1_latency", n, 3);
        check("t1_araddr", last_rise_addr, 32'hBFC0_0000);
        check("t1_if_pc", if_pc, 32'hBFC0_0000);
        check("t1_if_inst", if_inst, 32'h2408_0001);
        wait_rise("t1_next", a);
        check("t1_next_araddr", a, 32'hBFC0_0004);

        // 2: slow slave, exactly one pulse per transaction
        const_data = 0;
        do_reset();
        ar_delay = 3; r_delay = 2;
        next_pc_valid = 1'b1;
        wait_rise("t2_first", a);
        v0 = valid_cnt;
        wait_rise("t2_second", a);
        check("t2_one_pulse", valid_cnt - v0, 1);
        check("t2_second_araddr", a, 32'hBFC0_0004);

        // 3: branch resolved while the delay-slot word is in the data phase
        do_reset();
        ar_delay = 0; r_delay = 0;
        next_pc_valid = 1'b1;
        wait_rise("t3_a", a);
        wait_rise("t3_b", a);
        wait_rise("t3_c", a);
        check("t3_slot_araddr", a, 32'hBFC0_0008);
        tick();
        branch_flag = 1'b1; branch_target = 32'h8000_0100;
        tick();
        branch_flag = 1'b0;
        check("t3_slot_valid", valid, 1);
        check("t3_slot_pc", if_pc, 32'hBFC0_0008);
        wait_rise("t3_target", a);
        check("t3_target_araddr", a, 32'h8000_0100);

        // 4: flush in the address phase before arready
        do_reset();
        ar_delay = 4; r_delay = 0;
        next_pc_valid = 1'b1;
        wait_rise("t4_a", a);
        flush = 1'b1; new_pc = 32'hBFC0_0380;
        tick();
        flush = 1'b0;
        check("t4_arvalid_held", arvalid, 1);
        v0 = valid_cnt;
        wait_rise("t4_b", a);
        check("t4_dropped", valid_cnt - v0, 0);
        check("t4_new_araddr", a, 32'hBFC0_0380);

        // 5: flush coincident with rvalid, pending branch must be discarded
        do_reset();
        ar_delay = 0; r_delay = 0;
        next_pc_valid = 1'b1;
        wait_rise("t5_a", a);
        branch_flag = 1'b1; branch_target = 32'h8000_0100;
        tick();
        branch_flag = 1'b0;
        flush = 1'b1; new_pc = 32'hBFC0_0380;
        tick();
        flush = 1'b0;
        check("t5_no_valid", valid, 0);
        v0 = valid_cnt;
        wait_rise("t5_b", a);
        check("t5_flush_araddr", a, 32'hBFC0_0380);
        wait_rise("t5_c", a);
        check("t5_seq_araddr", a, 32'hBFC0_0384);
        check("t5_one_pulse", valid_cnt - v0, 1);

        // Randomized run with random wait states, stalls, branches, flushes, resets
        do_reset();
        rand_delays = 1;
        v0 = valid_cnt;
        for (int i = 0; i < 3000; i++) begin
            next_pc_valid = ($urandom_range(0, 9) < 8);
            rnd = $urandom;
            stall = (rnd[3:0] == 4'd0) ? 6'h01 : {rnd[9:5], 1'b0};
            flush = ($urandom_range(0, 39) == 0);
            rnd = $urandom;
            new_pc = rnd & 32'hFFFF_FFFC;
            branch_flag = ($urandom_range(0, 19) == 0);
            rnd = $urandom;
            branch_target = rnd & 32'hFFFF_FFFC;
            rst = ($urandom_range(0, 499) == 0);
            tick();
        end
        check("random_progress", (valid_cnt - v0 > 50) ? 32'd1 : 32'd0, 32'd1);

        // 6: misaligned flush target
        rand_delays = 0;
        do_reset();
        ar_delay = 0; r_delay = 0;
        mon_en = 0;
        flush = 1'b1; new_pc = 32'hBFC0_0002;
        tick();
        flush = 1'b0;
        next_pc_valid = 1'b1;
`ifdef INST_FETCH_ALIGN_CHECK_EN
        r0 = rise_cnt;
        v0 = valid_cnt;
        n = 0;
        while (valid_cnt == v0 && n < 10) begin
            tick();
            n++;
        end
        check("t6_valid_seen", (valid_cnt != v0) ? 32'd1 : 32'd0, 32'd1);
        check("t6_adel", if_excp_adel, 1);
        check("t6_if_inst", if_inst, 32'd0);
        check("t6_if_pc", if_pc, 32'hBFC0_0002);
        check("t6_no_ar", rise_cnt - r0, 0);
`else
        wait_rise("t6", a);
        check("t6_araddr", a, 32'hBFC0_0002);
        check("t6_adel_tied", if_excp_adel, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
